vector_list: RTL and testbench
==============================

VECTOR_LIST -- requirements
Module: vector_list

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003 host_we  in  1  host write strobe for one vector entry.
REQ-004 host_addr  in  10  host entry index, 0..1023.
REQ-005 host_data  in  56  entry {col[15:0], y1, x1, y0, x0}, each coordinate 10 bits, x0 in bits [9:0].
REQ-006 host_commit  in  1  edit list complete; request bank swap.
REQ-007 host_count  in  11  number of valid entries in committed list, 0..1024; sampled with host_commit.
REQ-008 host_ready  out  1  high when a host_we or host_commit is accepted this cycle.
REQ-009 trigger  in  1  start-of-frame pulse, shared with line engine.
REQ-010 vector  in  10  entry index requested by line engine.
REQ-011 read_vector  in  1  line engine read enable.
REQ-012 x0, y0, x1, y1  out  10 each  entry coordinates, registered.
REQ-013 col  out  16  entry colour, registered.
REQ-014 last_vector  out  1  registered; requested index is at or past end of display list.

Function
REQ-015 The block SHALL hold two 1024x56 banks: the display bank, read by the line engine, and the edit bank, written by the host.
REQ-016 Read latency SHALL be 1: the cycle after read_vector=1 with vector=v, outputs SHALL present display-bank entry v and last_vector=(v >= disp_count).
REQ-017 While read_vector=0, all line-side outputs SHALL hold their previous values.
REQ-018 A host write SHALL be accepted when host_we=1 and host_ready=1; host_data SHALL then be written to edit-bank entry host_addr at that edge.
REQ-019 Writes with host_ready=0 SHALL be dropped; no entry in either bank changes.
REQ-020 The swap FSM SHALL have states IDLE, PENDING and SWAP.
REQ-021 IDLE->PENDING on host_commit with host_ready=1; host_count SHALL be latched as pend_count.
REQ-022 PENDING->SWAP on trigger; SWAP->IDLE unconditionally after one cycle.
REQ-023 In SWAP, the bank select SHALL toggle and disp_count SHALL load pend_count.
REQ-024 Line-side reads issued during the SWAP cycle SHALL use the old bank; later reads SHALL use the new bank.
REQ-025 host_ready SHALL be 1 only in IDLE.
REQ-026 If host_commit arrives in the same cycle as trigger in IDLE, the FSM SHALL go to PENDING; the swap SHALL wait for the next trigger.
REQ-027 If host_we and host_commit are both accepted in the same cycle, the write SHALL land in the edit bank before the swap.
REQ-028 host_count greater than 1024 SHALL saturate to 1024.
REQ-029 With disp_count=0, every read SHALL return last_vector=1.
REQ-030 Edit-bank contents SHALL not be cleared by a swap; the host owns the old display bank as-is.

Reset
REQ-031 With rst_n=0: FSM=IDLE, bank select=0, disp_count=0, pend_count=0, x0=y0=x1=y1=0, col=0, last_vector=1, host_ready=0.
REQ-032 host_ready SHALL rise one cycle after rst_n deasserts.
REQ-033 Bank RAM contents SHALL not be reset.
REQ-034 Reset asserted in PENDING or SWAP SHALL abandon the swap; the display bank reverts to bank 0.

Configuration
REQ-035 VECTOR_LIST_ORDER_EN defined: an accepted write with y1<y0 SHALL be stored with the endpoints exchanged ({x1,y1} in the x0/y0 fields and vice versa), guaranteeing y1>=y0.
REQ-036 VECTOR_LIST_ORDER_EN undefined: host_data SHALL be stored verbatim.

Verification
REQ-037 Reset, then read_vector=1 with vector=0 -> next cycle last_vector=1, all coordinates 0.
REQ-038 Write entries 0..2, commit with host_count=3, then trigger -> reads of v=0..2 return the written data with last_vector=0; v=3 returns last_vector=1.
REQ-039 Commit, then host_we before trigger -> host_ready=0 and the write is dropped; after the swap, the edit bank is unchanged at that address.
REQ-040 read_vector=1 for v=5, then read_vector=0 for 4 cycles while vector changes -> outputs stay at entry 5.
REQ-041 Commit and trigger in the same cycle -> no swap; the swap occurs exactly at the following trigger.
REQ-042 With VECTOR_LIST_ORDER_EN, write x0=10, y0=100, x1=20, y1=50 -> readback x0=20, y0=50, x1=10, y1=100.

Source files
------------

// File: rtl/vector_list_if.sv
// Host and line-engine signal bundle for vector_list.
// The master side is the host/line engine; the slave side is the vector_list block.
interface vector_list_if;
  // Host edit port
  logic        host_we;
  logic [9:0]  host_addr;
  logic [55:0] host_data;
  logic        host_commit;
  logic [10:0] host_count;
  logic        host_ready;

  // Line engine read port
  logic        trigger;
  logic [9:0]  vector;
  logic        read_vector;
  logic [9:0]  x0;
  logic [9:0]  y0;
  logic [9:0]  x1;
  logic [9:0]  y1;
  logic [15:0] col;
  logic        last_vector;

  modport master (
    output host_we, host_addr, host_data, host_commit, host_count,
    output trigger, vector, read_vector,
    input  host_ready, x0, y0, x1, y1, col, last_vector
  );

  modport slave (
    input  host_we, host_addr, host_data, host_commit, host_count,
    input  trigger, vector, read_vector,
    output host_ready, x0, y0, x1, y1, col, last_vector
  );
endinterface

// File: rtl/vector_list.sv
// Double-buffered 1024-entry vector display list: host edits one bank while the
// line engine reads the other; a commit swaps banks at the next frame trigger.
// Optional macro VECTOR_LIST_ORDER_EN: store each written vector with y1 >= y0.
module vector_list (
  input  logic          clk,
  input  logic          rst_n,
  vector_list_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_t;

  localparam logic [10:0] MAX_COUNT = 11'd1024;

  state_t      state, state_nxt;
  logic        ready_en;
  logic        host_ready_c;
  logic        bank_sel;
  logic [10:0] disp_count;
  logic [10:0] pend_count;
  logic [10:0] count_sat;
  logic        we_acc;
  logic        commit_acc;
  logic [55:0] wr_data;
  logic [55:0] rd_data;

  logic [55:0] bank0 [1024];
  logic [55:0] bank1 [1024];

  logic [9:0]  x0_q, y0_q, x1_q, y1_q;
  logic [15:0] col_q;
  logic        last_q;

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    state_nxt    = state;
    host_ready_c = 1'b0;
    case (state)
      IDLE: begin
        host_ready_c = ready_en;
        if (bus.host_commit && ready_en) state_nxt = PENDING;
      end
      PENDING: if (bus.trigger) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign we_acc     = bus.host_we && host_ready_c;
  assign commit_acc = bus.host_commit && host_ready_c;
  assign count_sat  = (bus.host_count > MAX_COUNT) ? MAX_COUNT : bus.host_count;

`ifdef VECTOR_LIST_ORDER_EN
  // Exchange endpoints when y1 < y0 so the line engine always walks downward.
  always_comb begin
    wr_data = bus.host_data;
    if (bus.host_data[39:30] < bus.host_data[19:10])
      wr_data = {bus.host_data[55:40], bus.host_data[19:10], bus.host_data[9:0],
                 bus.host_data[39:30], bus.host_data[29:20]};
  end
`else
  assign wr_data = bus.host_data;
`endif

  // NOTE: the RAM banks carry no reset so they map onto plain block memory;
  // their contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we_acc) begin
      if (bank_sel) bank0[bus.host_addr] <= wr_data;
      else          bank1[bus.host_addr] <= wr_data;
    end
  end

  assign rd_data = bank_sel ? bank1[bus.vector] : bank0[bus.vector];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready_en   <= 1'b0;
      bank_sel   <= 1'b0;
      disp_count <= '0;
      pend_count <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      col_q      <= '0;
      last_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (commit_acc) pend_count <= count_sat;
      // Reads in the SWAP cycle still see the old bank; the toggle lands at this edge.
      if (state == SWAP) begin
        bank_sel   <= ~bank_sel;
        disp_count <= pend_count;
      end
      if (bus.read_vector) begin
        {col_q, y1_q, x1_q, y0_q, x0_q} <= rd_data;
        last_q <= ({1'b0, bus.vector} >= disp_count);
      end
    end
  end

  assign bus.host_ready  = host_ready_c;
  assign bus.x0          = x0_q;
  assign bus.y0          = y0_q;
  assign bus.x1          = x1_q;
  assign bus.y1          = y1_q;
  assign bus.col         = col_q;
  assign bus.last_vector = last_q;

endmodule

// File: tb/tb_vector_list.sv
// Self-checking bench for vector_list: directed scenarios followed by random
// traffic, all checked against a behavioural two-bank display-list model.
module tb_vector_list;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vector_list_if bus ();

  vector_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: two banks, which one is on display, and the swap request.
  logic [55:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  int          m_disp;
  int          m_count;
  int          m_pend;
  bit          m_wait;
  bit          m_swap;
  bit          m_ready_en;

  // Expected line-side outputs (held between reads)
  logic [55:0] e_data;
  bit          e_known;
  bit          e_last;

  function automatic logic [55:0] mk(int x0, int y0, int x1, int y1, int c);
    logic [9:0] a, b, p, q;
    logic [15:0] cc;
    a = 10'(x0); b = 10'(y0); p = 10'(x1); q = 10'(y1); cc = 16'(c);
    return {cc, q, p, b, a};
  endfunction

  function automatic logic [55:0] stored(logic [55:0] d);
`ifdef VECTOR_LIST_ORDER_EN
    int x0, y0, x1, y1, c;
    x0 = int'(d[9:0]);   y0 = int'(d[19:10]);
    x1 = int'(d[29:20]); y1 = int'(d[39:30]);
    c  = int'(d[55:40]);
    if (y1 < y0) return mk(x1, y1, x0, y0, c);
    return d;
`else
    return d;
`endif
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("last_vector", 64'(bus.last_vector), 64'(e_last));
    if (e_known)
      check("entry", 64'({bus.col, bus.y1, bus.x1, bus.y0, bus.x0}), 64'(e_data));
  endtask

  // Apply the currently driven inputs for one clock, updating the model.
  task automatic step();
    bit rdy;
    int cnt;
    rdy = m_ready_en && !m_wait && !m_swap;
    check("host_ready", 64'(bus.host_ready), 64'(rdy));
    if (bus.read_vector) begin
      e_known = m_known[m_disp][bus.vector];
      e_data  = m_mem[m_disp][bus.vector];
      e_last  = int'(bus.vector) >= m_count;
    end
    if (bus.host_we && rdy) begin
      m_mem[1-m_disp][bus.host_addr]   = stored(bus.host_data);
      m_known[1-m_disp][bus.host_addr] = 1'b1;
    end
    if (m_swap) begin
      m_disp  = 1 - m_disp;
      m_count = m_pend;
      m_swap  = 1'b0;
    end else if (m_wait) begin
      if (bus.trigger) begin
        m_wait = 1'b0;
        m_swap = 1'b1;
      end
    end else if (rdy && bus.host_commit) begin
      cnt    = int'(bus.host_count);
      m_pend = (cnt > 1024) ? 1024 : cnt;
      m_wait = 1'b1;
    end
    m_ready_en = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drive(bit we, int addr, logic [55:0] data, bit commit, int count,
                       bit trig, bit rd, int vec);
    bus.host_we     = we;
    bus.host_addr   = 10'(addr);
    bus.host_data   = data;
    bus.host_commit = commit;
    bus.host_count  = 11'(count);
    bus.trigger     = trig;
    bus.read_vector = rd;
    bus.vector      = 10'(vec);
    step();
  endtask

  task automatic idle();              drive(0, 0, '0, 0, 0, 0, 0, 0);       endtask
  task automatic write(int a, logic [55:0] d); drive(1, a, d, 0, 0, 0, 0, 0); endtask
  task automatic commit(int n);       drive(0, 0, '0, 1, n, 0, 0, 0);       endtask
  task automatic trig();              drive(0, 0, '0, 0, 0, 1, 0, 0);       endtask
  task automatic rd(int v);           drive(0, 0, '0, 0, 0, 0, 1, v);       endtask

  // Asynchronous reset, asserted away from the clock edge.
  task automatic do_reset();
    bus.host_we = 0; bus.host_commit = 0; bus.trigger = 0; bus.read_vector = 0;
    bus.host_addr = '0; bus.host_data = '0; bus.host_count = '0; bus.vector = '0;
    rst_n = 1'b0;
    #1;
    m_disp = 0; m_count = 0; m_pend = 0;
    m_wait = 0; m_swap = 0; m_ready_en = 0;
    e_data = '0; e_known = 1'b1; e_last = 1'b1;
    check("reset_ready", 64'(bus.host_ready), 64'(0));
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [55:0] d;
    #2;
    do_reset();

    // host_ready rises one cycle after reset release; empty list reads last.
    idle();
    idle();
    rd(0);
    rd(3);

    // Fill edit bank: entries 0..2, plus 5 and 7 beyond the committed count.
    for (int i = 0; i < 3; i++) write(i, {$urandom, $urandom});
    write(5, mk(55, 66, 77, 88, 16'h1234));
    write(7, mk(1, 2, 3, 4, 16'hbeef));
    commit(3);
    // Dropped write while the swap is pending.
    write(7, mk(9, 9, 9, 9, 16'hdead));
    idle();
    trig();
    idle();
    for (int v = 0; v < 4; v++) rd(v);
    rd(7);

    // Outputs hold while read_vector is low.
    rd(5);
    for (int i = 0; i < 4; i++) drive(0, 0, '0, 0, 0, 0, 0, $urandom_range(0, 1023));

    // Commit together with trigger: the swap waits for the next trigger.
    for (int i = 0; i < 5; i++) write(i, {$urandom, $urandom});
    drive(0, 0, '0, 1, 5, 1, 0, 0);
    idle();
    idle();
    rd(4);
    rd(0);
    trig();
    drive(0, 0, '0, 0, 0, 0, 1, 1);   // read in SWAP cycle sees old bank
    rd(4);
    rd(5);

    // Endpoint ordering, write+commit same cycle, and count saturation.
    d = mk(10, 100, 20, 50, 16'h0a5a);
    drive(1, 10, d, 1, 2000, 0, 0, 0);
    trig();
    idle();
    rd(10);
    rd(1023);

    // Reset while pending abandons the swap and returns to bank 0.
    write(11, mk(3, 1, 4, 1, 16'h5926));
    commit(12);
    idle();
    do_reset();
    idle();
    rd(0);
    rd(10);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0), $urandom_range(0, 15), {$urandom, $urandom},
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 7) == 0) ? 2047 : $urandom_range(0, 20),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 0),
            $urandom_range(0, 20));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
